// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic in-order pipeline-stage buffer carrying
// {instruction, PC, bubble} between two valid/ready handshakes.
// Squashed fetches are stored as NOP bubbles; flush empties the stage.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/ready  upstream handshake; in_ready depends only on count
//   instr_in, pc_in incoming instruction and its PC
//   squash_in       store the accepted entry as a NOP bubble
//   flush           discard all buffered entries
//   out_valid/ready downstream handshake on the head entry
//   instr_out, pc_out, bubble_out  head entry (NOP/0/1 when empty)
//   count           current occupancy
module pipe_stage_elastic #(
  parameter int unsigned         INSTR_W   = 16,
  parameter int unsigned         PC_W      = 16,
  parameter int unsigned         DEPTH     = 2,
  parameter int unsigned         CNT_W     = 2,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(16'h0800)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               squash_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               bubble_out,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] instr_q  [DEPTH];
  logic [PC_W-1:0]    pc_q     [DEPTH];
  logic               bubble_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push, pop;

  // Explicit wrap so non-power-of-two depths cycle correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake qualification; flush cancels both sides.
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a squashed push becomes a NOP bubble that keeps its PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i]  <= NOP_INSTR;
        pc_q[i]     <= '0;
        bubble_q[i] <= 1'b1;
      end
    end else if (push) begin
      instr_q[wr_ptr_q]  <= squash_in ? NOP_INSTR : instr_in;
      pc_q[wr_ptr_q]     <= pc_in;
      bubble_q[wr_ptr_q] <= squash_in;
    end
  end

  // Head presentation; an empty stage shows a NOP bubble at PC 0.
  always_comb begin
    instr_out  = NOP_INSTR;
    pc_out     = '0;
    bubble_out = 1'b1;
    if (out_valid) begin
      instr_out  = instr_q[rd_ptr_q];
      pc_out     = pc_q[rd_ptr_q];
      bubble_out = bubble_q[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default DEPTH=2
  logic        a_rst, a_in_valid, a_in_ready, a_squash, a_flush;
  logic        a_out_valid, a_out_ready, a_bubble;
  logic [15:0] a_instr_in, a_pc_in, a_instr_out, a_pc_out;
  logic [1:0]  a_count;

  pipe_stage_elastic #(.DEPTH(2), .CNT_W(2)) dut_a (
    .clk(clk), .rst(a_rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .instr_in(a_instr_in), .pc_in(a_pc_in),
    .squash_in(a_squash), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .instr_out(a_instr_out), .pc_out(a_pc_out),
    .bubble_out(a_bubble), .count(a_count)
  );

  // DUT B: DEPTH=3 for wrap-around
  logic        b_rst, b_in_valid, b_in_ready, b_squash, b_flush;
  logic        b_out_valid, b_out_ready, b_bubble;
  logic [15:0] b_instr_in, b_pc_in, b_instr_out, b_pc_out;
  logic [1:0]  b_count;

  pipe_stage_elastic #(.DEPTH(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(b_rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instr_in(b_instr_in), .pc_in(b_pc_in),
    .squash_in(b_squash), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .instr_out(b_instr_out), .pc_out(b_pc_out),
    .bubble_out(b_bubble), .count(b_count)
  );

  typedef struct {
    logic        rst, in_valid;
    logic [15:0] instr, pc;
    logic        squash, flush, out_ready;
    logic        e_ov, e_ir;
    logic [15:0] e_instr, e_pc;
    logic        e_bub;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic r, input logic iv,
                              input logic [15:0] ins, input logic [15:0] p,
                              input logic sq, input logic fl, input logic orr,
                              input logic eov, input logic eir,
                              input logic [15:0] ein, input logic [15:0] ep,
                              input logic eb, input logic [1:0] ec);
    vec_t v;
    v.rst = r; v.in_valid = iv; v.instr = ins; v.pc = p;
    v.squash = sq; v.flush = fl; v.out_ready = orr;
    v.e_ov = eov; v.e_ir = eir; v.e_instr = ein; v.e_pc = ep;
    v.e_bub = eb; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    // rst iv instr pc sq fl or | ov ir instr pc bub cnt
    vecs[0]  = mk(1,0,16'h0000,16'h0000,0,0,0, 0,1,16'h0800,16'h0000,1,2'd0); // reset
    vecs[1]  = mk(1,0,16'h0000,16'h0000,0,0,0, 0,1,16'h0800,16'h0000,1,2'd0);
    vecs[2]  = mk(0,1,16'h1234,16'h0002,0,0,1, 1,1,16'h1234,16'h0002,0,2'd1); // pass-through
    vecs[3]  = mk(0,0,16'h0000,16'h0000,0,0,1, 0,1,16'h0800,16'h0000,1,2'd0);
    vecs[4]  = mk(0,1,16'hA001,16'h0004,0,0,0, 1,1,16'hA001,16'h0004,0,2'd1); // fill
    vecs[5]  = mk(0,1,16'hB002,16'h0006,0,0,0, 1,0,16'hA001,16'h0004,0,2'd2); // full
    vecs[6]  = mk(0,1,16'hC003,16'h0008,0,0,0, 1,0,16'hA001,16'h0004,0,2'd2); // C held
    vecs[7]  = mk(0,1,16'hC003,16'h0008,0,0,1, 1,1,16'hB002,16'h0006,0,2'd1); // pop A only
    vecs[8]  = mk(0,1,16'hC003,16'h0008,0,0,1, 1,1,16'hC003,16'h0008,0,2'd1); // push C + pop B
    vecs[9]  = mk(0,0,16'h0000,16'h0000,0,0,1, 0,1,16'h0800,16'h0000,1,2'd0); // pop C
    vecs[10] = mk(0,1,16'h5A5A,16'h0010,1,0,0, 1,1,16'h0800,16'h0010,1,2'd1); // squash
    vecs[11] = mk(0,1,16'h1111,16'h0012,0,0,0, 1,0,16'h0800,16'h0010,1,2'd2);
    vecs[12] = mk(0,1,16'h2222,16'h0014,0,1,1, 0,1,16'h0800,16'h0000,1,2'd0); // flush
    vecs[13] = mk(0,0,16'h0000,16'h0000,0,0,1, 0,1,16'h0800,16'h0000,1,2'd0);
    vecs[14] = mk(0,1,16'h3333,16'h0020,0,0,0, 1,1,16'h3333,16'h0020,0,2'd1);
    vecs[15] = mk(0,1,16'h4444,16'h0022,0,0,0, 1,0,16'h3333,16'h0020,0,2'd2);
    vecs[16] = mk(1,1,16'h5555,16'h0024,0,1,0, 0,1,16'h0800,16'h0000,1,2'd0); // rst mid-op
    vecs[17] = mk(0,1,16'h6666,16'h0026,0,0,0, 1,1,16'h6666,16'h0026,0,2'd1);
    vecs[18] = mk(0,0,16'h0000,16'h0000,0,0,1, 0,1,16'h0800,16'h0000,1,2'd0);
  end

  initial begin
    int sent, rcvd;
    logic [15:0] exp_i, exp_p;

    a_rst = 1; a_in_valid = 0; a_instr_in = '0; a_pc_in = '0;
    a_squash = 0; a_flush = 0; a_out_ready = 0;
    b_rst = 1; b_in_valid = 0; b_instr_in = '0; b_pc_in = '0;
    b_squash = 0; b_flush = 0; b_out_ready = 0;

    // Table-driven vectors on DUT A: inputs before the edge, check after it.
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      a_rst = vecs[k].rst; a_in_valid = vecs[k].in_valid;
      a_instr_in = vecs[k].instr; a_pc_in = vecs[k].pc;
      a_squash = vecs[k].squash; a_flush = vecs[k].flush;
      a_out_ready = vecs[k].out_ready;
      @(posedge clk);
      #1;
      n_cmp++;
      if (a_out_valid !== vecs[k].e_ov || a_in_ready !== vecs[k].e_ir ||
          a_instr_out !== vecs[k].e_instr || a_pc_out !== vecs[k].e_pc ||
          a_bubble !== vecs[k].e_bub || a_count !== vecs[k].e_cnt) begin
        n_fail++;
        $display("FAIL vec%0d: got ov=%b ir=%b instr=%h pc=%h bub=%b cnt=%0d, want ov=%b ir=%b instr=%h pc=%h bub=%b cnt=%0d",
                 k, a_out_valid, a_in_ready, a_instr_out, a_pc_out, a_bubble, a_count,
                 vecs[k].e_ov, vecs[k].e_ir, vecs[k].e_instr, vecs[k].e_pc,
                 vecs[k].e_bub, vecs[k].e_cnt);
      end
    end

    // Wrap-around stream on DUT B (DEPTH=3), out_ready toggling 1,0,1,...
    @(negedge clk);
    b_rst = 1;
    @(negedge clk);
    b_rst = 0;
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 100 && rcvd < 10; cyc++) begin
      b_in_valid  = (sent < 10);
      b_instr_in  = 16'hC000 + 16'(sent);
      b_pc_in     = 16'(2 * sent);
      b_out_ready = (cyc % 2 == 0);
      #1;
      n_cmp++;
      if (b_count > 2'd3 || b_in_ready !== (b_count != 2'd3) || b_out_valid !== (b_count != 2'd0)) begin
        n_fail++;
        $display("FAIL wrap_cnt cyc%0d: got cnt=%0d ir=%b ov=%b, want cnt<=3 consistent flags",
                 cyc, b_count, b_in_ready, b_out_valid);
      end
      if (b_out_valid && b_out_ready) begin
        exp_i = 16'hC000 + 16'(rcvd);
        exp_p = 16'(2 * rcvd);
        n_cmp++;
        if (b_instr_out !== exp_i || b_pc_out !== exp_p || b_bubble !== 1'b0) begin
          n_fail++;
          $display("FAIL wrap_item%0d: got instr=%h pc=%h bub=%b, want instr=%h pc=%h bub=0",
                   rcvd, b_instr_out, b_pc_out, b_bubble, exp_i, exp_p);
        end
        rcvd++;
      end
      if (b_in_valid && b_in_ready) sent++;
      @(negedge clk);
    end
    b_in_valid = 0; b_out_ready = 0;
    n_cmp++;
    if (rcvd != 10) begin
      n_fail++;
      $display("FAIL wrap_total: got %0d items, want 10", rcvd);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (b_count !== 2'd0 || b_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_drain: got cnt=%0d ov=%b, want cnt=0 ov=0", b_count, b_out_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic pipeline-stage register that generalises the fixed IF/ID latch. It is a DEPTH-entry in-order buffer carrying {instruction, PC, bubble} with a valid/ready handshake on both sides. It supports NOP substitution for squashed fetches and a synchronous flush. It sits between fetch and decode, and may be reused at any stage boundary that carries an instruction and a PC.

Parameters:
INSTR_W, 16, instruction width in bits
PC_W, 16, PC width in bits
DEPTH, 2, number of buffer entries; legal for any DEPTH >= 1, not only powers of two
CNT_W, 2, occupancy width; must satisfy 2^CNT_W > DEPTH
NOP_INSTR, 16'h0800, INSTR_W-bit encoding substituted for squashed or empty slots

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept this cycle
instr_in  input  INSTR_W  instruction from instruction memory
pc_in  input  PC_W  PC paired with instr_in
squash_in  input  1  branch/jump kill; the accepted entry is stored as a NOP
flush  input  1  discard all buffered entries
out_valid  output  1  head entry is presented
out_ready  input  1  downstream consumes the head this cycle
instr_out  output  INSTR_W  head instruction, or NOP_INSTR when empty
pc_out  output  PC_W  head PC, or 0 when empty
bubble_out  output  1  head entry is a substituted NOP (suppresses halt/dump in control)
count  output  CNT_W  current occupancy

Behaviour:
- Storage: a circular buffer of DEPTH entries, each {instr, pc, bubble}. Read and write pointers wrap explicitly from DEPTH-1 to 0.
- Reset (rst=1 at an edge): count=0, pointers=0, every entry's bubble=1 and instr=NOP_INSTR.
  - Outputs in the following cycle: out_valid=0, instr_out=NOP_INSTR, pc_out=0, bubble_out=1, in_ready=1, count=0.
  - rst overrides flush, push and pop.
- in_ready = (count != DEPTH). It is derived from registered count only; there is no combinational path from out_ready.
- push = in_valid & in_ready & ~flush
  - The entry is written at the write pointer.
  - If squash_in=1: instr is stored as NOP_INSTR, pc as pc_in, bubble=1.
  - Otherwise instr=instr_in, pc=pc_in, bubble=0.
  - squash_in is ignored when push is 0.
- pop = out_valid & out_ready & ~flush. It advances the read pointer.
- Outputs are combinational from registered state:
  - out_valid = (count != 0).
  - If count=0: instr_out=NOP_INSTR, pc_out=0, bubble_out=1.
  - If count!=0: instr_out, pc_out and bubble_out come from the head entry.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. There is no same-cycle bypass.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Full (count=DEPTH): in_ready=0, so no push occurs. A pop that cycle makes in_ready=1 the next cycle.
- Empty: pop cannot occur because out_valid=0.
- flush=1 at an edge:
  - count←0 and both pointers←0.
  - Any push or pop in the same cycle is discarded and has no effect.
  - Next cycle the stage is empty: out_valid=0, instr_out=NOP_INSTR, bubble_out=1.
- Priority: rst > flush > push/pop.
- Upstream must hold instr_in and pc_in stable while in_valid=1 and in_ready=0. Downstream sees the head stable while out_valid=1 and out_ready=0.
- count never exceeds DEPTH and never underflows.

Test Plan:
1. Reset, then single pass-through: rst for 2 cycles, then push {16'h1234, PC 16'h0002}, out_ready=1.
   - During reset: out_valid=0, instr_out=16'h0800.
   - One cycle after the push: out_valid=1, instr_out=16'h1234, pc_out=16'h0002, bubble_out=0, count=1.
   - Next cycle: count=0.
2. Backpressure fill (DEPTH=2): out_ready=0, push A=16'hA001 then B=16'hB002.
   - After the second push: count=2, in_ready=0, head=A.
   - A third push of C is held off while in_ready=0.
   - Raise out_ready: outputs are A, then B, then C in order, and C is never dropped or duplicated.
3. Squash: push 16'h5A5A with squash_in=1 and PC 16'h0010.
   - Output: instr_out=16'h0800, pc_out=16'h0010, bubble_out=1, out_valid=1.
4. Flush with simultaneous push and pop: count=2, flush=1, in_valid=1, out_ready=1 in the same cycle.
   - Next cycle: count=0, out_valid=0, instr_out=16'h0800.
   - The pushed entry never appears on the outputs.
5. Wrap-around with DEPTH=3: stream 10 entries with out_ready toggling 1,0,1,…
   - All 10 emerge in order with correct PCs.
   - count stays within 0..3 throughout; pointers wrap cleanly past index 2.
6. Reset mid-operation: count=2, assert rst together with flush and in_valid.
   - Next cycle: count=0, in_ready=1, out_valid=0, pc_out=0.
